mul255_serial: RTL and testbench
================================

Name: mul255_serial

Overview:
- Downstream checker stage for the divide-by-255 unit.
- Consumes the 32-bit quotient Y over the same 16-bit, flag-sequenced bus: MSB half first, then LSB half.
- Reconstructs P = Y*255 = (Y<<8) - Y with a byte-serial borrow chain, one byte per cycle.
- Returns the low 32 bits of P in two 16-bit halves, plus an overflow flag. Used to confirm X = 255*Y for exact multiples.

Parameters:
- None. Widths are fixed: 16-bit bus, 32-bit operand, 40-bit internal product.

Ports:
- clk    input   1   rising-edge clock; only clock.
- rst    input   1   reset; synchronous, active-high.
- x      input   16  operand half (Y[31:16], then Y[15:0]).
- flg1   input   1   start: leave IDLE.
- flg2   input   1   MSB half done; go to LSB capture.
- flg3   input   1   host has read MSB result half; advance.
- flg4   input   1   host has read LSB result half; return to IDLE.
- y      output  16  result half (registered).
- ovf    output  1   P[39:32] != 0 (registered).
- busy   output  1   high in every state except IDLE (registered).

Behaviour:
- State register cs holds one of: IDLE, LDM, LDL, INIT, B0, B1, B2, B3, B4, OUTM, OUTL.
- Every transition is evaluated on the current state and the current-cycle flags, and takes effect at the next rising edge. Flags are ignored outside the state that uses them.
- rst=1 at an edge overrides everything, mid-operation included:
  - cs=IDLE, y=0, ovf=0, busy=0.
  - Yreg, P, borrow cleared.
- IDLE:
  - y<=0, ovf<=0.
  - flg1 -> LDM; else stay.
- LDM:
  - Yreg[31:16]<=x on every edge spent here; the last sample wins.
  - flg2 -> LDL; else stay.
- LDL: Yreg[15:0]<=x; -> INIT unconditionally.
- INIT: P<=0, borrow<=0; -> B0.
- Byte chain, bytes Yi = Yreg[8i+7:8i]; each step's borrow-out is registered for the next step:
  - B0: P[7:0] <= 0 - Y0 - 0 -> B1.
  - B1: P[15:8] <= Y0 - Y1 - b -> B2.
  - B2: P[23:16] <= Y1 - Y2 - b -> B3.
  - B3: P[31:24] <= Y2 - Y3 - b -> B4.
  - B4: P[39:32] <= Y3 - 0 - b -> OUTM.
  - Borrow-out of B4 is always 0 (256Y >= Y); it is not stored.
- On the B4->OUTM edge:
  - y<=P[31:16] (bytes 3..2, already final).
  - ovf<=(Y3 - b != 0), i.e. the byte written in B4.
- OUTM:
  - y holds P[31:16].
  - flg3 -> OUTL, with y<=P[15:0] on that edge.
- OUTL:
  - y holds P[15:0].
  - flg4 -> IDLE, with y<=0 and ovf<=0 on that edge.
- Latency: edge entering OUTM is the 7th edge after the edge entering LDL (LDL, INIT, B0..B4).
- Simultaneous flags:
  - Only the flag of the current state matters; e.g. flg1..flg4 all high in IDLE -> LDM only.
  - Flags held high step one state per cycle, never skip states.
- ovf and y stay stable while waiting in OUTM/OUTL for any number of cycles.
- busy=1 from the edge leaving IDLE until the edge returning to IDLE.

Test Plan:
- Y=0x00000101 -> y=0x0000 in OUTM, then 0xFFFF in OUTL; ovf=0; OUTM reached exactly 7 edges after entering LDL.
- Y=0x01010101 -> y=0xFFFF then 0xFFFF; ovf=0 (full borrow ripple through all bytes).
- Y=0xFFFFFFFF -> y=0xFFFF then 0xFF01; ovf=1 (P=0xFEFFFFFF01).
- Y=0x00000000 with flg1..flg4 held high throughout -> one state per cycle; y=0x0000, 0x0000; ovf=0; back to IDLE with busy=0.
- In LDM, x=0x1234 then 0x00AB before flg2; LSB=0x0000 -> MSB captured as 0x00AB; y=0xAA55 then 0x0000; ovf=0.
- Assert rst during B2, then run Y=0x00000101 -> y=0, ovf=0, busy=0 the next edge; IDLE; the fresh run gives the same result as the first scenario with no stale borrow.

Source files
------------

// File: rtl/mul255_serial.sv
// mul255_serial: rebuilds P = Y*255 = (Y<<8) - Y one byte per cycle with a
// registered borrow chain, then returns P[31:0] as two 16-bit halves.
// The overflow flag reports a non-zero P[39:32].
//
// Flag handshake:
//   Each flag is a one-cycle "advance" request that is honoured only in the
//   state that owns it. flg1 is used in IDLE, flg2 in LDM, flg3 in OUTM and
//   flg4 in OUTL. The FSM acts on the flag at the next rising edge.
//   Flags seen in any other state are ignored.
//   A flag held high moves the FSM forward by exactly one state per cycle.
module mul255_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic        flg1,
  input  logic        flg2,
  input  logic        flg3,
  input  logic        flg4,
  output logic [15:0] y,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, LDM, LDL, INIT, B0, B1, B2, B3, B4, OUTM, OUTL
  } state_t;

  state_t      cs;
  logic [31:0] yreg;
  // Only the low 32 bits of P are kept. Byte 4 of P exists only to drive ovf,
  // so it is taken straight from the chain in B4.
  logic [31:0] p;
  logic        b;

  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [8:0]  diff;

  // Operand select for the current byte step: P_i = Y_(i-1) - Y_i - borrow.
  always_comb begin
    opa = 8'd0;
    opb = 8'd0;
    case (cs)
      B0: begin opa = 8'd0;         opb = yreg[7:0];   end
      B1: begin opa = yreg[7:0];    opb = yreg[15:8];  end
      B2: begin opa = yreg[15:8];   opb = yreg[23:16]; end
      B3: begin opa = yreg[23:16];  opb = yreg[31:24]; end
      B4: begin opa = yreg[31:24];  opb = 8'd0;        end
      default: begin opa = 8'd0;    opb = 8'd0;        end
    endcase
    // A 9-bit difference: bit 8 is set exactly when the byte step borrows.
    diff = {1'b0, opa} - {1'b0, opb} - {8'd0, b};
  end

  // FSM: state, operand capture, byte chain and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= IDLE;
      yreg <= 32'd0;
      p    <= 32'd0;
      b    <= 1'b0;
      y    <= 16'd0;
      ovf  <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (cs)
        IDLE: begin
          y   <= 16'd0;
          ovf <= 1'b0;
          if (flg1) begin
            cs   <= LDM;
            busy <= 1'b1;
          end
        end
        LDM: begin
          yreg[31:16] <= x;
          if (flg2) cs <= LDL;
        end
        LDL: begin
          yreg[15:0] <= x;
          cs         <= INIT;
        end
        INIT: begin
          p  <= 32'd0;
          b  <= 1'b0;
          cs <= B0;
        end
        B0: begin
          p[7:0] <= diff[7:0];
          b      <= diff[8];
          cs     <= B1;
        end
        B1: begin
          p[15:8] <= diff[7:0];
          b       <= diff[8];
          cs      <= B2;
        end
        B2: begin
          p[23:16] <= diff[7:0];
          b        <= diff[8];
          cs       <= B3;
        end
        B3: begin
          p[31:24] <= diff[7:0];
          b        <= diff[8];
          cs       <= B4;
        end
        B4: begin
          // Because 256*Y >= Y, the top byte never borrows, so its borrow is not kept.
          y   <= p[31:16];
          ovf <= (diff[7:0] != 8'd0);
          cs  <= OUTM;
        end
        OUTM: begin
          if (flg3) begin
            y  <= p[15:0];
            cs <= OUTL;
          end
        end
        OUTL: begin
          if (flg4) begin
            y    <= 16'd0;
            ovf  <= 1'b0;
            busy <= 1'b0;
            cs   <= IDLE;
          end
        end
        default: begin
          cs   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul255_serial.sv
// Directed bench for mul255_serial. The expected values are worked out by hand from Y*255.
module tb_mul255_serial;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic        flg1, flg2, flg3, flg4;
  logic [15:0] y;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul255_serial dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .flg1 (flg1),
    .flg2 (flg2),
    .flg3 (flg3),
    .flg4 (flg4),
    .y    (y),
    .ovf  (ovf),
    .busy (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Full transaction that starts and ends in IDLE.
  // flg3 stays high from LDL until OUTM is entered. If OUTM came one edge early,
  // the FSM would move on to OUTL and y would show the wrong half.
  task automatic run_op(input string tag, input logic [31:0] yv, input logic use_junk,
                        input logic [15:0] junk, input logic [15:0] exp_m,
                        input logic [15:0] exp_l, input logic exp_ovf, input int hold);
    flg1 = 1'b1;
    step();                                   // -> LDM
    flg1 = 1'b0;
    check({tag, "_busy_ldm"}, busy, 1);
    if (use_junk) begin
      x = junk;
      step();                                 // stay in LDM, capture junk
    end
    x    = yv[31:16];
    flg2 = 1'b1;
    step();                                   // -> LDL
    flg2 = 1'b0;
    x    = yv[15:0];
    flg3 = 1'b1;
    for (int i = 0; i < 6; i++) step();       // INIT, B0..B4
    check({tag, "_y_b4"}, y, 0);
    step();                                   // edge 7 -> OUTM
    flg3 = 1'b0;
    x    = 16'h0;
    check({tag, "_y_msb"}, y, exp_m);
    check({tag, "_ovf"}, ovf, exp_ovf);
    for (int i = 0; i < hold; i++) step();
    if (hold > 0) begin
      check({tag, "_y_msb_hold"}, y, exp_m);
      check({tag, "_ovf_hold"}, ovf, exp_ovf);
    end
    flg3 = 1'b1;
    step();                                   // -> OUTL
    flg3 = 1'b0;
    check({tag, "_y_lsb"}, y, exp_l);
    check({tag, "_ovf_lsb"}, ovf, exp_ovf);
    for (int i = 0; i < hold; i++) step();
    if (hold > 0) check({tag, "_y_lsb_hold"}, y, exp_l);
    flg4 = 1'b1;
    step();                                   // -> IDLE
    flg4 = 1'b0;
    check({tag, "_y_idle"}, y, 0);
    check({tag, "_ovf_idle"}, ovf, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; x = 16'h0;
    flg1 = 1'b0; flg2 = 1'b0; flg3 = 1'b0; flg4 = 1'b0;
    step();
    step();
    check("rst_y", y, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // 0x101*255 = 0xFFFF
    run_op("y0101", 32'h0000_0101, 1'b0, 16'h0, 16'h0000, 16'hFFFF, 1'b0, 3);
    // 0x01010101*255 = 0xFFFFFFFF, the borrow ripples through every byte
    run_op("y01s", 32'h0101_0101, 1'b0, 16'h0, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    // 0xFFFFFFFF*255 = 0xFE_FFFFFF01
    run_op("yffff", 32'hFFFF_FFFF, 1'b0, 16'h0, 16'hFFFF, 16'hFF01, 1'b1, 2);
    // the last sample in LDM wins: Y=0x00AB0000 -> 0xAA550000
    run_op("ldm_last", 32'h00AB_0000, 1'b1, 16'h1234, 16'hAA55, 16'h0000, 1'b0, 0);

    // All flags held high with Y=0: one state per edge, and IDLE returns at edge 11.
    x = 16'h0;
    flg1 = 1'b1; flg2 = 1'b1; flg3 = 1'b1; flg4 = 1'b1;
    step();
    check("flags_busy_e1", busy, 1);
    for (int i = 0; i < 8; i++) step();       // edge 9 -> OUTM
    check("flags_busy_e9", busy, 1);
    check("flags_y_msb", y, 0);
    step();                                   // edge 10 -> OUTL
    check("flags_busy_e10", busy, 1);
    check("flags_y_lsb", y, 0);
    check("flags_ovf", ovf, 0);
    step();                                   // edge 11 -> IDLE
    flg1 = 1'b0; flg2 = 1'b0; flg3 = 1'b0; flg4 = 1'b0;
    check("flags_busy_e11", busy, 0);
    step();
    check("flags_busy_stay", busy, 0);

    // Reset asserted in B2 while a borrow is pending (Y=0xFFFFFFFF)
    flg1 = 1'b1; step(); flg1 = 1'b0;
    x = 16'hFFFF; flg2 = 1'b1; step(); flg2 = 1'b0;   // LDL
    x = 16'hFFFF;
    for (int i = 0; i < 4; i++) step();       // INIT, B0, B1, B2
    check("b2_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("b2rst_y", y, 0);
    check("b2rst_ovf", ovf, 0);
    check("b2rst_busy", busy, 0);
    step();
    check("b2rst_idle", busy, 0);
    run_op("after_rst", 32'h0000_0101, 1'b0, 16'h0, 16'h0000, 16'hFFFF, 1'b0, 1);

    // Reset in OUTM clears a set ovf and a non-zero y
    flg1 = 1'b1; step(); flg1 = 1'b0;
    x = 16'hFFFF; flg2 = 1'b1; step(); flg2 = 1'b0;
    x = 16'hFFFF;
    for (int i = 0; i < 7; i++) step();       // -> OUTM
    check("outm_y", y, 16'hFFFF);
    check("outm_ovf", ovf, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("outmrst_y", y, 0);
    check("outmrst_ovf", ovf, 0);
    check("outmrst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // A global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
